modexp_seq: RTL
===============

# modexp_seq

Parametrised operand/result sequencer between a host and the `ModExp` core. Slices five OP_WIDTH-bit operands (message, exponent, modulus, r, t) into WORD_WIDTH-bit words and streams them into the core, along with nprime0. It then waits for the core's COMPLETE state, reassembles the result words into an OP_WIDTH-bit register and reports done or timeout. Replaces the hand-written bench loader and adds generic widths, latency alignment, abort and timeout.

## Interface
- OP_WIDTH, 4096, operand/result width in bits; must be a multiple of WORD_WIDTH
- WORD_WIDTH, 64, core word width (`DATA_WIDTH`)
- NUM_WORDS, OP_WIDTH/WORD_WIDTH, words per operand (derived, not overridable)
- COMPLETE_CODE, 9, `exp_state` value meaning the result is ready
- RES_LATENCY, 1, READ cycles discarded before the first valid `res_out` word
- TIMEOUT_CYCLES, 2^24, maximum WAIT cycles before error
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  job request; sampled only in IDLE
- abort  input  1  synchronous abort, any state
- message, exponent, modulus, r_in, t_in  input  OP_WIDTH  operands; held stable by host while busy=1
- nprime0_in  input  WORD_WIDTH  -n^-1 mod 2^WORD_WIDTH
- m_buf, e_buf, n_buf, r_buf, t_buf  output  WORD_WIDTH  registered operand words to core
- nprime0  output  WORD_WIDTH  registered copy of nprime0_in, captured at start
- startInput, startCompute, getResult  output  1  core control levels
- exp_state  input  5  core state
- res_out  input  WORD_WIDTH  core result word stream
- result  output  OP_WIDTH  assembled result; held until next accepted start
- busy  output  1  high from accepted start until return to IDLE
- done  output  1  one-cycle pulse at job end
- error  output  1  valid with done: 1 = timeout

## Operation
- States: IDLE, LOAD, WAIT, READ, FIN.
- IDLE: busy=0. Accepts start=1 with abort=0 in the same cycle. On accept: capture nprime0, clear word counter, startInput<=1, busy<=1, go to LOAD.
- LOAD: each cycle, drive word k = bits [k*WORD_WIDTH +: WORD_WIDTH] of each operand onto *_buf, then k<=k+1. Runs for exactly NUM_WORDS cycles, k = 0..NUM_WORDS-1, LSW first.
- After the last word: startCompute<=1, getResult<=1, clear timeout counter, go to WAIT. startInput stays 1 until FIN.
- WAIT: when exp_state==COMPLETE_CODE, clear counter and go to READ. Otherwise the timeout counter increments. On reaching TIMEOUT_CYCLES: error<=1, go to FIN.
- READ: runs RES_LATENCY+NUM_WORDS cycles. Cycle j ≥ RES_LATENCY writes res_out into result word j-RES_LATENCY. After the last word, go to FIN.
- FIN: done=1 for one cycle; all core strobes <=0; busy<=0; return to IDLE.
- Word counter is $clog2(RES_LATENCY+NUM_WORDS+1) bits and never wraps inside a state. Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.
- abort: from any non-IDLE state go to IDLE next cycle. Strobes, busy and error go to 0. No done pulse. result is left partial and undefined.
- start while busy=1 is ignored and not queued.
- error clears on the next accepted start. result is not cleared by a timeout.

## Timing
- Reset (reset=0): state IDLE; every output 0, including result, *_buf and nprime0. Takes effect immediately, mid-job included. After release, the block needs a fresh start.
- Job accepted at edge T0: startInput=1 and busy=1 after T0. Word k is on *_buf after edge T0+1+k.
- startCompute and getResult rise after edge T0+NUM_WORDS+1.
- COMPLETE seen at edge Tc: the READ capture of res_out occurs at edges Tc+1+RES_LATENCY+i, for result word i.
- done pulses after edge Tc+RES_LATENCY+NUM_WORDS+1. result is stable in the same cycle.
- Minimum job latency, start to done, with COMPLETE seen on the first WAIT cycle: 2*NUM_WORDS+RES_LATENCY+3 cycles.
- Timeout: done and error assert TIMEOUT_CYCLES+1 cycles after WAIT entry.
- start in the FIN cycle is ignored. start in the cycle after FIN is accepted, giving back-to-back jobs with one idle cycle.

## Test plan
- OP_WIDTH=256, WORD_WIDTH=64, message word k = 0x1000+k. Expect m_buf = 0x1000,0x1001,0x1002,0x1003 on consecutive cycles after start; startCompute rises on the following cycle.
- Behavioural core model with modulus=77, message=8, exponent=13: result=50, error=0, and done arrives exactly at the computed cycle.
- RES_LATENCY=2, model streams 0xA0..0xA3 delayed by 2 cycles: result = {0xA3,0xA2,0xA1,0xA0}.
- TIMEOUT_CYCLES=16, exp_state held at 3: done=1 with error=1 sixteen-plus-one cycles after WAIT entry; all strobes 0 afterwards.
- abort asserted at LOAD word 2: IDLE next cycle, busy=0, no done. A following start completes normally.
- reset pulled low mid-READ: all outputs 0 asynchronously. start during busy=1 has no effect.

Source files
------------

// File: rtl/modexp_seq.sv
// Operand/result sequencer for the ModExp core: streams operand words in LSW first,
// waits for the core to report COMPLETE, then reassembles the result words.
module modexp_seq #(
  parameter int unsigned OP_WIDTH       = 4096,
  parameter int unsigned WORD_WIDTH     = 64,
  parameter logic [4:0]  COMPLETE_CODE  = 5'd9,
  parameter int unsigned RES_LATENCY    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [OP_WIDTH-1:0]   message,
  input  logic [OP_WIDTH-1:0]   exponent,
  input  logic [OP_WIDTH-1:0]   modulus,
  input  logic [OP_WIDTH-1:0]   r_in,
  input  logic [OP_WIDTH-1:0]   t_in,
  input  logic [WORD_WIDTH-1:0] nprime0_in,
  output logic [WORD_WIDTH-1:0] m_buf,
  output logic [WORD_WIDTH-1:0] e_buf,
  output logic [WORD_WIDTH-1:0] n_buf,
  output logic [WORD_WIDTH-1:0] r_buf,
  output logic [WORD_WIDTH-1:0] t_buf,
  output logic [WORD_WIDTH-1:0] nprime0,
  output logic                  startInput,
  output logic                  startCompute,
  output logic                  getResult,
  input  logic [4:0]            exp_state,
  input  logic [WORD_WIDTH-1:0] res_out,
  output logic [OP_WIDTH-1:0]   result,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned NUM_WORDS = OP_WIDTH / WORD_WIDTH;
  localparam int unsigned CNT_W     = $clog2(RES_LATENCY + NUM_WORDS + 1);
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_READ, S_FIN} state_e;

  state_e                               state_q;
  logic [CNT_W-1:0]                     cnt_q;
  logic [TMO_W-1:0]                     tmo_q;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] res_q;

  // Word-indexed views of the operands
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] m_words, e_words, n_words, r_words, t_words;
  logic [IDX_W-1:0]                     ld_idx, rd_idx;

  assign m_words = message;
  assign e_words = exponent;
  assign n_words = modulus;
  assign r_words = r_in;
  assign t_words = t_in;
  assign ld_idx  = IDX_W'(cnt_q);
  assign rd_idx  = IDX_W'(cnt_q - CNT_W'(RES_LATENCY));
  assign result  = res_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      res_q        <= '0;
      m_buf        <= '0;
      e_buf        <= '0;
      n_buf        <= '0;
      r_buf        <= '0;
      t_buf        <= '0;
      nprime0      <= '0;
      startInput   <= 1'b0;
      startCompute <= 1'b0;
      getResult    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      // Abort drops the job silently: no done pulse, result left as is
      state_q      <= S_IDLE;
      startInput   <= 1'b0;
      startCompute <= 1'b0;
      getResult    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            nprime0    <= nprime0_in;
            cnt_q      <= '0;
            startInput <= 1'b1;
            busy       <= 1'b1;
            error      <= 1'b0;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt_q == CNT_W'(NUM_WORDS)) begin
            startCompute <= 1'b1;
            getResult    <= 1'b1;
            tmo_q        <= '0;
            state_q      <= S_WAIT;
          end else begin
            m_buf <= m_words[ld_idx];
            e_buf <= e_words[ld_idx];
            n_buf <= n_words[ld_idx];
            r_buf <= r_words[ld_idx];
            t_buf <= t_words[ld_idx];
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (exp_state == COMPLETE_CODE) begin
            cnt_q   <= '0;
            state_q <= S_READ;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
            error   <= 1'b1;
            done    <= 1'b1;
            state_q <= S_FIN;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_READ: begin
          // The first RES_LATENCY words on res_out are pipeline fill and are dropped
          if (cnt_q == CNT_W'(RES_LATENCY + NUM_WORDS)) begin
            done    <= 1'b1;
            state_q <= S_FIN;
          end else begin
            if (cnt_q >= CNT_W'(RES_LATENCY)) begin
              res_q[rd_idx] <= res_out;
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FIN: begin
          startInput   <= 1'b0;
          startCompute <= 1'b0;
          getResult    <= 1'b0;
          busy         <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
